// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable data bits, stop length and runtime parity,
// feeding a first-word-fall-through FIFO with per-entry error flags.
module uart_rx_cfg #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [10:0]     dvsr,
  input  logic [1:0]      par_mode,
  input  logic            rx,
  input  logic            rd_uart,
  input  logic            clr_ovr,
  output logic [DBIT-1:0] r_data,
  output logic            r_perr,
  output logic            r_ferr,
  output logic            rx_empty,
  output logic            rx_full,
  output logic            overrun,
  output logic            break_det
);

  localparam int SW    = $clog2(SB_TICK);
  localparam int NW    = $clog2(DBIT);
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int EW    = DBIT + 2;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic [1:0]      mode;
  logic            perr;
  logic            pbit;
  logic [10:0]     tcnt;
  logic            tick;
  logic            push;
  logic            ferr_now;
  logic [EW-1:0]   wdata;

  logic [EW-1:0]         mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [CW-1:0]         count;
  logic                  rd_ok;
  logic                  wr_ok;
  logic [EW-1:0]         head;

  // Comparing with >= lets a shrinking dvsr recover instead of wrapping the counter.
  assign tick = (tcnt >= dvsr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tcnt <= '0;
    else        tcnt <= tick ? '0 : tcnt + 11'd1;
  end

  assign push     = (state == STOP) && tick && (s == SW'(SB_TICK - 1));
  assign ferr_now = ~rx;
  assign wdata    = {ferr_now, perr, b};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      b         <= '0;
      mode      <= 2'b00;
      perr      <= 1'b0;
      pbit      <= 1'b0;
      break_det <= 1'b0;
    end else begin
      // pbit stays 0 in no-parity frames, so only data and stop decide a break.
      break_det <= push && (b == '0) && ferr_now && !pbit;
      unique case (state)
        IDLE: begin
          if (!rx) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s == SW'(7)) begin
              if (!rx) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
                mode  <= par_mode;
                perr  <= 1'b0;
                pbit  <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == SW'(15)) begin
              s <= '0;
              b <= {rx, b[DBIT-1:1]};
              if (n == NW'(DBIT - 1))
                state <= ((mode == 2'b01) || (mode == 2'b10)) ? PARITY : STOP;
              else
                n <= n + NW'(1);
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (s == SW'(15)) begin
              s     <= '0;
              pbit  <= rx;
              perr  <= (mode == 2'b10) ? ~(^b ^ rx) : (^b ^ rx);
              state <= STOP;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s == SW'(SB_TICK - 1)) state <= IDLE;
            else                       s     <= s + SW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_empty = (count == '0);
  assign rx_full  = count[ADDR_WIDTH];
  assign rd_ok    = rd_uart && !rx_empty;
  // A pop in the same clk frees the slot, so a full FIFO can still accept the push.
  assign wr_ok    = push && (!rx_full || rd_uart);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + ADDR_WIDTH'(1);
      if (rd_ok) rptr <= rptr + ADDR_WIDTH'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             overrun <= 1'b0;
    else if (push && rx_full && !rd_uart)   overrun <= 1'b1;
    else if (clr_ovr)                       overrun <= 1'b0;
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign head   = mem[rptr];
  assign r_data = rx_empty ? '0 : head[DBIT-1:0];
  assign r_perr = rx_empty ? 1'b0 : head[DBIT];
  assign r_ferr = rx_empty ? 1'b0 : head[DBIT+1];

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: frames are serialised at 80 clk/bit and
// the expected FIFO contents are queued as each frame is driven.
module tb_uart_rx_cfg;

  localparam int BIT_CLK = 80;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic [1:0]  par_mode;
  logic        rx;
  logic        rd_uart;
  logic        clr_ovr;
  logic [7:0]  r_data;
  logic        r_perr;
  logic        r_ferr;
  logic        rx_empty;
  logic        rx_full;
  logic        overrun;
  logic        break_det;

  typedef struct packed {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   brk_cnt = 0;
  int   brk_long = 0;
  logic brk_prev = 1'b0;
  logic model_ovr = 1'b0;

  uart_rx_cfg #(.DBIT(8), .SB_TICK(16), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .par_mode(par_mode), .rx(rx),
    .rd_uart(rd_uart), .clr_ovr(clr_ovr), .r_data(r_data), .r_perr(r_perr),
    .r_ferr(r_ferr), .rx_empty(rx_empty), .rx_full(rx_full),
    .overrun(overrun), .break_det(break_det)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (break_det) begin
      brk_cnt = brk_cnt + 1;
      if (brk_prev) brk_long = brk_long + 1;
    end
    brk_prev = break_det;
  end

  task automatic bit_time(input logic v);
    rx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // A low stop bit is released early so the receiver rejects the trailing low as a glitch.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode,
                            input logic [1:0] late_mode, input logic pbit,
                            input logic stop);
    exp_t e;
    logic haspar;
    haspar = (mode == 2'b01) || (mode == 2'b10);
    e.d    = d;
    e.perr = haspar ? ((mode == 2'b10) ? ~(^d ^ pbit) : (^d ^ pbit)) : 1'b0;
    e.ferr = ~stop;
    if (q.size() < 4) q.push_back(e);
    else              model_ovr = 1'b1;
    par_mode = mode;
    bit_time(1'b0);
    par_mode = late_mode;
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (haspar) bit_time(pbit);
    if (stop) begin
      bit_time(1'b1);
    end else begin
      rx = 1'b0;
      repeat (60) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
  endtask

  task automatic wait_data(input string name);
    for (int i = 0; i < 1000 && rx_empty; i++) @(negedge clk);
    total++;
    if (rx_empty !== 1'b0) begin
      bad++;
      $display("FAIL %s timeout: rx_empty=%b want 0", name, rx_empty);
    end
  endtask

  task automatic drain_entry(input string name);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = q.pop_front();
    total++;
    if (r_data !== e.d) begin
      bad++;
      $display("FAIL %s data: got %h want %h", name, r_data, e.d);
    end
    total++;
    if (r_perr !== e.perr) begin
      bad++;
      $display("FAIL %s perr: got %b want %b", name, r_perr, e.perr);
    end
    total++;
    if (r_ferr !== e.ferr) begin
      bad++;
      $display("FAIL %s ferr: got %b want %b", name, r_ferr, e.ferr);
    end
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; rx = 1'b1; rd_uart = 1'b0; clr_ovr = 1'b0;
    dvsr = 11'd4; par_mode = 2'b00;
    repeat (3) @(negedge clk);
    total += 7;
    if (rx_empty !== 1'b1)  begin bad++; $display("FAIL rst_empty: got %b want 1", rx_empty); end
    if (rx_full !== 1'b0)   begin bad++; $display("FAIL rst_full: got %b want 0", rx_full); end
    if (overrun !== 1'b0)   begin bad++; $display("FAIL rst_ovr: got %b want 0", overrun); end
    if (break_det !== 1'b0) begin bad++; $display("FAIL rst_brk: got %b want 0", break_det); end
    if (r_data !== 8'h00)   begin bad++; $display("FAIL rst_data: got %h want 00", r_data); end
    if (r_perr !== 1'b0)    begin bad++; $display("FAIL rst_perr: got %b want 0", r_perr); end
    if (r_ferr !== 1'b0)    begin bad++; $display("FAIL rst_ferr: got %b want 0", r_ferr); end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
    @(negedge clk);
    total += 2;
    if (rx_empty !== 1'b1) begin bad++; $display("FAIL rd_on_empty empty: got %b want 1", rx_empty); end
    if (rx_full !== 1'b0)  begin bad++; $display("FAIL rd_on_empty full: got %b want 0", rx_full); end
  endtask

  task automatic test_no_parity();
    send_frame(8'h55, 2'b00, 2'b00, 1'b0, 1'b1);
    wait_data("nopar_wait");
    drain_entry("nopar_55");
    total++;
    if (rx_empty !== 1'b1) begin bad++; $display("FAIL nopar_drained: got %b want 1", rx_empty); end
  endtask

  task automatic test_parity();
    send_frame(8'hDF, 2'b01, 2'b01, 1'b0, 1'b1);
    send_frame(8'hDF, 2'b01, 2'b01, 1'b1, 1'b1);
    send_frame(8'h0F, 2'b10, 2'b10, 1'b0, 1'b1);
    wait_data("par_wait");
    drain_entry("even_bad");
    drain_entry("even_good");
    drain_entry("odd_bad");
  endtask

  task automatic test_par_latch();
    send_frame(8'hDF, 2'b01, 2'b00, 1'b0, 1'b1);
    wait_data("latch_wait");
    drain_entry("latch_even");
  endtask

  task automatic test_break();
    int c0, l0;
    c0 = brk_cnt; l0 = brk_long;
    send_frame(8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
    wait_data("brk_wait");
    total += 2;
    if (brk_cnt - c0 !== 1)  begin bad++; $display("FAIL brk_pulses: got %0d want 1", brk_cnt - c0); end
    if (brk_long - l0 !== 0) begin bad++; $display("FAIL brk_width: got %0d extra want 0", brk_long - l0); end
    drain_entry("brk_00");
    c0 = brk_cnt;
    send_frame(8'h81, 2'b00, 2'b00, 1'b0, 1'b0);
    wait_data("ferr_wait");
    total++;
    if (brk_cnt - c0 !== 0) begin bad++; $display("FAIL nobrk_81: got %0d pulses want 0", brk_cnt - c0); end
    drain_entry("ferr_81");
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (25) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    total++;
    if (rx_empty !== 1'b1) begin bad++; $display("FAIL glitch_push: rx_empty=%b want 1", rx_empty); end
    send_frame(8'hA3, 2'b00, 2'b00, 1'b0, 1'b1);
    wait_data("glitch_wait");
    drain_entry("after_glitch_A3");
  endtask

  task automatic test_overrun();
    model_ovr = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 2'b00, 2'b00, 1'b0, 1'b1);
    total += 2;
    if (rx_full !== 1'b1)      begin bad++; $display("FAIL ovr_full: got %b want 1", rx_full); end
    if (overrun !== model_ovr) begin bad++; $display("FAIL ovr_set: got %b want %b", overrun, model_ovr); end
    for (int i = 1; i <= 4; i++) drain_entry("ovr_read");
    total += 2;
    if (rx_empty !== 1'b1)     begin bad++; $display("FAIL ovr_empty: got %b want 1", rx_empty); end
    if (overrun !== model_ovr) begin bad++; $display("FAIL ovr_sticky: got %b want %b", overrun, model_ovr); end
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    model_ovr = 1'b0;
    total++;
    if (overrun !== model_ovr) begin bad++; $display("FAIL ovr_clear: got %b want %b", overrun, model_ovr); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    send_frame(8'h11, 2'b00, 2'b00, 1'b0, 1'b1);
    wait_data("mid_prefill");
    d = 8'h5A;
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(d[i]);
    rx = d[3];
    repeat (BIT_CLK / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    q.delete();
    total += 2;
    if (rx_empty !== 1'b1) begin bad++; $display("FAIL mid_rst_empty: got %b want 1", rx_empty); end
    if (r_data !== 8'h00)  begin bad++; $display("FAIL mid_rst_data: got %h want 00", r_data); end
    repeat (10) @(negedge clk);
    rx = 1'b1;
    reset = 1'b1;
    repeat (200) @(negedge clk);
    total++;
    if (rx_empty !== 1'b1) begin bad++; $display("FAIL mid_rst_partial: rx_empty=%b want 1", rx_empty); end
    send_frame(8'h3C, 2'b00, 2'b00, 1'b0, 1'b1);
    wait_data("mid_rst_wait");
    drain_entry("after_rst_3C");
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_par_latch();
    test_break();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
